// File: rtl/block_dispatcher.sv
// Splits a kernel's threads into fixed-size blocks and hands them to compute
// cores over a per-core start/done handshake; raises done once all retire.
module block_dispatcher #(
   parameter int NUM_CORES         = 2,
   parameter int THREADS_PER_BLOCK = 4,
   localparam int TW               = $clog2(THREADS_PER_BLOCK) + 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [7:0]              thread_count,
   input  logic [NUM_CORES-1:0]    core_done,
   output logic [NUM_CORES-1:0]    core_start,
   output logic [NUM_CORES-1:0]    core_reset,
   output logic [NUM_CORES*8-1:0]  core_block_id,
   output logic [NUM_CORES*TW-1:0] core_thread_count,
   output logic                    done
);
   localparam int LOG2_TPB = $clog2(THREADS_PER_BLOCK);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state_reg, state_next;
   logic [7:0]           tc_reg, tc_next;
   logic [7:0]           total_reg, total_next;
   logic [7:0]           disp_reg, disp_next;
   logic [7:0]           bdone_reg, bdone_next;
   logic [NUM_CORES-1:0] start_reg, start_next;
   logic [NUM_CORES-1:0] creset_reg, creset_next;
   logic [7:0]           id_reg [NUM_CORES];
   logic [7:0]           id_next [NUM_CORES];
   logic [TW-1:0]        cnt_reg [NUM_CORES];
   logic [TW-1:0]        cnt_next [NUM_CORES];
   logic                 done_reg, done_next;

   logic [7:0]           disp_acc;
   logic [7:0]           bdone_acc;
   logic [15:0]          rem;

   always_comb begin
      state_next  = state_reg;
      tc_next     = tc_reg;
      total_next  = total_reg;
      disp_next   = disp_reg;
      bdone_next  = bdone_reg;
      start_next  = start_reg;
      creset_next = creset_reg;
      id_next     = id_reg;
      cnt_next    = cnt_reg;
      done_next   = done_reg;
      disp_acc    = disp_reg;
      bdone_acc   = bdone_reg;
      rem         = '0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               tc_next     = thread_count;
               // ceil() needs the ninth bit: 255 + (TPB-1) overflows 8 bits
               total_next  = 8'(({1'b0, thread_count} + 9'(THREADS_PER_BLOCK - 1)) >> LOG2_TPB);
               disp_next   = '0;
               bdone_next  = '0;
               creset_next = '1;
               state_next  = RUN;
            end
         end
         RUN: begin
            if (bdone_reg == total_reg) begin
               done_next   = 1'b1;
               creset_next = '0;
               state_next  = DONE;
            end else begin
               // Running tally so lower-indexed cores claim lower block ids
               for (int i = 0; i < NUM_CORES; i++) begin
                  if (creset_reg[i]) begin
                     creset_next[i] = 1'b0;
                  end else if (start_reg[i] && core_done[i]) begin
                     start_next[i]  = 1'b0;
                     creset_next[i] = 1'b1;
                     bdone_acc      = bdone_acc + 8'd1;
                  end else if (!start_reg[i] && (disp_acc < total_reg)) begin
                     start_next[i] = 1'b1;
                     id_next[i]    = disp_acc;
                     rem           = 16'(tc_reg) - (16'(disp_acc) << LOG2_TPB);
                     if (rem >= 16'(THREADS_PER_BLOCK))
                        cnt_next[i] = TW'(THREADS_PER_BLOCK);
                     else
                        cnt_next[i] = rem[TW-1:0];
                     disp_acc = disp_acc + 8'd1;
                  end
               end
               disp_next  = disp_acc;
               bdone_next = bdone_acc;
            end
         end
         DONE: begin
            if (!start) begin
               done_next  = 1'b0;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= IDLE;
         tc_reg     <= '0;
         total_reg  <= '0;
         disp_reg   <= '0;
         bdone_reg  <= '0;
         start_reg  <= '0;
         creset_reg <= '0;
         done_reg   <= 1'b0;
         for (int i = 0; i < NUM_CORES; i++) begin
            id_reg[i]  <= '0;
            cnt_reg[i] <= '0;
         end
      end else begin
         state_reg  <= state_next;
         tc_reg     <= tc_next;
         total_reg  <= total_next;
         disp_reg   <= disp_next;
         bdone_reg  <= bdone_next;
         start_reg  <= start_next;
         creset_reg <= creset_next;
         done_reg   <= done_next;
         for (int i = 0; i < NUM_CORES; i++) begin
            id_reg[i]  <= id_next[i];
            cnt_reg[i] <= cnt_next[i];
         end
      end
   end

   assign core_start = start_reg;
   assign core_reset = creset_reg;
   assign done       = done_reg;

   for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_pack
      assign core_block_id[8*gi +: 8]      = id_reg[gi];
      assign core_thread_count[TW*gi +: TW] = cnt_reg[gi];
   end

endmodule

// File: tb/tb_block_dispatcher.sv
// Bench for block_dispatcher: a block-queue model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_block_dispatcher;
   localparam int NC  = 2;
   localparam int TPB = 4;
   localparam int TW  = $clog2(TPB) + 1;
   localparam int OW  = 2*NC + NC*8 + NC*TW + 1;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic [7:0]       thread_count = '0;
   logic [NC-1:0]    core_done = '0;
   logic [NC-1:0]    core_start;
   logic [NC-1:0]    core_reset;
   logic [NC*8-1:0]  core_block_id;
   logic [NC*TW-1:0] core_thread_count;
   logic             done;

   block_dispatcher #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB)) dut (
      .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
      .core_done(core_done), .core_start(core_start), .core_reset(core_reset),
      .core_block_id(core_block_id), .core_thread_count(core_thread_count),
      .done(done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int rise_total = 0;
   bit check_en = 1'b0;

   // Model: the kernel is a queue of block sizes; cores take the next entry.
   int            m_blocks[$];
   int            m_phase;       // 0 waiting for launch, 1 running, 2 finished
   int            m_next;
   int            m_retired;
   int            m_rem;
   logic [NC-1:0] m_st, m_rst;
   logic [7:0]    m_id [NC];
   logic [TW-1:0] m_cnt [NC];
   logic          m_done;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_phase = 0; m_next = 0; m_retired = 0; m_blocks.delete();
         m_st = '0; m_rst = '0; m_done = 1'b0;
         for (int i = 0; i < NC; i++) begin m_id[i] = '0; m_cnt[i] = '0; end
      end else if (m_phase == 0) begin
         if (start) begin
            m_blocks.delete();
            m_rem = int'(thread_count);
            while (m_rem > 0) begin
               m_blocks.push_back(m_rem > TPB ? TPB : m_rem);
               m_rem = m_rem - TPB;
            end
            m_next = 0; m_retired = 0; m_rst = '1; m_phase = 1;
         end
      end else if (m_phase == 1) begin
         if (m_retired == m_blocks.size()) begin
            m_done = 1'b1; m_rst = '0; m_phase = 2;
         end else begin
            for (int i = 0; i < NC; i++) begin
               if (m_rst[i]) m_rst[i] = 1'b0;
               else if (m_st[i] && core_done[i]) begin
                  m_st[i] = 1'b0; m_rst[i] = 1'b1; m_retired++;
               end else if (!m_st[i] && m_next < m_blocks.size()) begin
                  m_st[i] = 1'b1; m_id[i] = 8'(m_next);
                  m_cnt[i] = TW'(m_blocks[m_next]); m_next++;
               end
            end
         end
      end else if (!start) begin
         m_done = 1'b0; m_phase = 0;
      end
   end

   logic [NC-1:0] prev_start = '0;
   always @(negedge clk) begin
      logic [NC*8-1:0]  e_id;
      logic [NC*TW-1:0] e_cnt;
      logic [OW-1:0]    exp_v, act_v;
      if (check_en) begin
         for (int i = 0; i < NC; i++) begin
            e_id[8*i +: 8]   = m_id[i];
            e_cnt[TW*i +: TW] = m_cnt[i];
         end
         exp_v = {m_st, m_rst, e_id, e_cnt, m_done};
         act_v = {core_start, core_reset, core_block_id, core_thread_count, done};
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL cycle_model t=%0t actual=%h required=%h", $time, act_v, exp_v);
         end
         rise_total += $countones(core_start & ~prev_start);
         prev_start = core_start;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic wait_start(input logic [NC-1:0] mask, input string name);
      int n = 0;
      while (core_start !== mask && n < 50) begin @(negedge clk); n++; end
      chk(name, 32'(core_start), 32'(mask));
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (done !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      chk(name, 32'(done), 32'd1);
   endtask

   task automatic pulse_done(input logic [NC-1:0] mask);
      core_done = mask;
      @(negedge clk);
      core_done = '0;
   endtask

   int r0;

   initial begin
      // 1: asynchronous reset between edges
      #3 reset = 1'b1;
      #1 chk("async_reset_outputs", 32'({core_start, core_reset, core_block_id, core_thread_count, done}), 32'd0);
      check_en = 1'b1;
      @(negedge clk); #2 reset = 1'b0;
      @(negedge clk);
      chk("idle_after_reset", 32'({core_start, done}), 32'd0);

      // 2: eight threads -> two full blocks on both cores
      thread_count = 8'd8; start = 1'b1;
      @(negedge clk);
      chk("t2_core_reset_pulse", 32'(core_reset), 32'h3);
      wait_start(2'b11, "t2_dispatch");
      chk("t2_ids", 32'(core_block_id), 32'h0100);
      chk("t2_counts", 32'(core_thread_count), 32'({3'd4, 3'd4}));
      pulse_done(2'b11);
      chk("t2_retire_reset", 32'({core_start, core_reset}), 32'h3);
      @(negedge clk);
      chk("t2_done", 32'(done), 32'd1);
      start = 1'b0;
      @(negedge clk);
      chk("t2_done_clear", 32'(done), 32'd0);

      // 3: ten threads -> blocks of 4,4,2 with core0 reused
      thread_count = 8'd10; start = 1'b1; r0 = rise_total;
      wait_start(2'b11, "t3_first_dispatch");
      chk("t3_ids", 32'(core_block_id), 32'h0100);
      pulse_done(2'b01);
      chk("t3_core0_retire", 32'({core_start, core_reset}), 32'h9);
      wait_start(2'b11, "t3_redispatch");
      chk("t3_ids2", 32'(core_block_id), 32'h0102);
      chk("t3_counts2", 32'(core_thread_count), 32'({3'd4, 3'd2}));
      pulse_done(2'b11);
      wait_done("t3_done");
      chk("t3_start_rises", 32'(rise_total - r0), 32'd3);
      start = 1'b0;
      @(negedge clk);

      // 4: zero threads -> done with no dispatch
      thread_count = 8'd0; start = 1'b1; r0 = rise_total;
      @(negedge clk);
      chk("t4_not_yet_done", 32'({done, core_reset}), 32'h3);
      @(negedge clk);
      chk("t4_done", 32'(done), 32'd1);
      chk("t4_no_dispatch", 32'(rise_total - r0), 32'd0);
      start = 1'b0;
      @(negedge clk);

      // 5: abort mid-run with reset, then a one-block kernel
      thread_count = 8'd10; start = 1'b1;
      wait_start(2'b11, "t5_dispatch");
      #2 reset = 1'b1;
      #1 chk("t5_async_abort", 32'({core_start, core_reset, core_block_id, core_thread_count, done}), 32'd0);
      start = 1'b0;
      @(negedge clk); #2 reset = 1'b0;
      @(negedge clk);
      thread_count = 8'd4; start = 1'b1; r0 = rise_total;
      wait_start(2'b01, "t5_single_dispatch");
      chk("t5_count0", 32'(core_thread_count), 32'({3'd0, 3'd4}));
      thread_count = 8'd200;
      pulse_done(2'b01);
      wait_done("t5_done");
      chk("t5_rises", 32'(rise_total - r0), 32'd1);

      // 6: hold start in DONE, then drop and relaunch with one thread
      for (int k = 0; k < 5; k++) begin
         core_done = 2'b11;
         @(negedge clk);
         chk("t6_hold_done", 32'({done, core_start}), 32'h4);
      end
      core_done = '0; start = 1'b0;
      @(negedge clk);
      chk("t6_done_drop", 32'(done), 32'd0);
      thread_count = 8'd1; start = 1'b1;
      wait_start(2'b01, "t6_dispatch");
      chk("t6_count", 32'(core_thread_count[TW-1:0]), 32'd1);
      pulse_done(2'b01);
      wait_done("t6_done");
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule
